// File: rtl/apb_logic_sequencer_if.sv
// Request/response handshake and APB master bus of the logic-unit sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface apb_logic_sequencer_if #(
    parameter int unsigned NREQ = 2
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ*2-1:0]  req_op;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_data;
    logic               rsp_err;

    logic               PSEL;
    logic               PENABLE;
    logic               PWRITE;
    logic [31:0]        PADDR;
    logic [31:0]        PWDATA;
    logic [31:0]        PRDATA;
    logic               PREADY;
    logic               PSLVERR;

    modport master (
        input  req_valid, req_a, req_b, req_op, rsp_ready, PRDATA, PREADY, PSLVERR,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, rsp_ready, PRDATA, PREADY, PSLVERR,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
               PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_logic_sequencer.sv
// Shares one APB logic-unit slave between NREQ requesters: round-robin grant, then
// write A, write B, write control, read result, and return it on the response channel.
module apb_logic_sequencer #(
    parameter int unsigned NREQ      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_logic_sequencer_if.master bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t         state_q;
    logic [1:0]     step_q;
    logic [IDW-1:0] last_q;
    logic [IDW-1:0] id_q;
    logic [TW-1:0]  tcnt_q;
    logic [31:0]    a_q, b_q;
    logic [1:0]     op_q;

    logic           psel_q, penable_q, pwrite_q;
    logic [31:0]    paddr_q, pwdata_q;
    logic           rsp_valid_q, rsp_err_q;
    logic [IDW-1:0] rsp_id_q;
    logic [31:0]    rsp_data_q;

    function automatic logic [31:0] step_addr(input logic [1:0] s);
        return BASE_ADDR + 32'({s, 2'b00});
    endfunction

    function automatic logic [31:0] step_wdata(input logic [1:0] s, input logic [31:0] a,
                                               input logic [31:0] b, input logic [1:0] op);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return {30'b0, op};
            default: return 32'h0;
        endcase
    endfunction

    // Round-robin search starting just after the last granted requester
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IDW'((32'(last_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    logic [31:0] sel_a, sel_b;
    logic [1:0]  sel_op;
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant_idx) begin
                sel_a  = bus.req_a[32*k +: 32];
                sel_b  = bus.req_b[32*k +: 32];
                sel_op = bus.req_op[2*k +: 2];
            end
        end
    end

    // Accept pulse exists only while idle; it is the handshake itself
    logic [NREQ-1:0] ready_c;
    always_comb begin
        ready_c = '0;
        if (PRESETn && state_q == IDLE && grant_found) ready_c[grant_idx] = 1'b1;
    end

    logic       xfer_ok, abort_c;
    logic [1:0] step_n;
    assign xfer_ok = bus.PREADY & ~bus.PSLVERR;
    assign abort_c = (bus.PREADY & bus.PSLVERR) | (~bus.PREADY & (tcnt_q == TW'(TIMEOUT - 1)));
    assign step_n  = step_q + 2'd1;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            step_q      <= '0;
            last_q      <= IDW'(NREQ - 1);
            id_q        <= '0;
            tcnt_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        a_q       <= sel_a;
                        b_q       <= sel_b;
                        op_q      <= sel_op;
                        id_q      <= grant_idx;
                        last_q    <= grant_idx;
                        step_q    <= 2'd0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b1;
                        paddr_q   <= step_addr(2'd0);
                        pwdata_q  <= sel_a;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    tcnt_q    <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (abort_c || (xfer_ok && step_q == 2'd3)) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        pwrite_q    <= 1'b0;
                        paddr_q     <= '0;
                        pwdata_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_err_q   <= abort_c;
                        rsp_data_q  <= abort_c ? 32'h0 : bus.PRDATA;
                        state_q     <= RESP;
                    end else if (xfer_ok) begin
                        step_q    <= step_n;
                        penable_q <= 1'b0;
                        pwrite_q  <= (step_n != 2'd3);
                        paddr_q   <= step_addr(step_n);
                        pwdata_q  <= step_wdata(step_n, a_q, b_q, op_q);
                        state_q   <= SETUP;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
